// File: rtl/inst_queue_pkg.sv
// Shared types for the instruction fetch queue: the stored entry layout and
// the fetch exception code width seen by the decoder.
package inst_queue_pkg;

  localparam int EXC_W   = 4;
  localparam int ENTRY_W = 32 + 32 + EXC_W;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      ins;
    logic [EXC_W-1:0] exc;
  } queue_entry_t;

endpackage

// File: rtl/queue_ram.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one
// asynchronous read port used for first-word fall-through.
module queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and
  // count, so clearing storage would only cost a reset tree for nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction fetch queue between fetch and decode. Circular buffer with
// single-cycle flush; the head entry drives the decoder, zeroed when empty.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_ins,
  input  logic [EXC_W-1:0]         push_exc,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [31:0]              pop_pc,
  output logic [31:0]              pop_ins,
  output logic [EXC_W-1:0]         pop_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         push_fire, pop_fire;
  queue_entry_t wr_entry, rd_entry;

  // Flags come only from registered occupancy; no refill at full.
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);

  assign push_fire = push_valid && push_ready && !flush;
  assign pop_fire  = pop_valid && pop_ready && !flush;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) tail_d = tail_q + PTR_W'(1);
      if (pop_fire)  head_d = head_q + PTR_W'(1);
      if (push_fire && !pop_fire)      count_d = count_q + CNT_W'(1);
      else if (pop_fire && !push_fire) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign wr_entry = '{pc: push_pc, ins: push_ins, exc: push_exc};

  queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_fire),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_entry)
  );

  // Empty presents an all-zero NOP bubble to the decoder.
  assign pop_pc  = pop_valid ? rd_entry.pc  : '0;
  assign pop_ins = pop_valid ? rd_entry.ins : '0;
  assign pop_exc = pop_valid ? rd_entry.exc : '0;
  assign count   = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH = 4): ordering, full and
// empty boundaries, wrap, exception pass-through, flush and async reset.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_ins;
  logic [3:0]  push_exc;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_ins;
  logic [3:0]  pop_exc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_pc    (push_pc),
    .push_ins   (push_ins),
    .push_exc   (push_exc),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_pc     (pop_pc),
    .pop_ins    (pop_ins),
    .pop_exc    (pop_exc),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic [31:0] ins, input logic [3:0] exc);
    push_valid = 1'b1;
    push_pc    = pc;
    push_ins   = ins;
    push_exc   = exc;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_pc = '0; push_ins = '0; push_exc = '0;

    // Reset then idle
    #12;
    @(negedge clk) resetn = 1'b1;
    step();
    check("rst_pop_valid",  pop_valid,  0);
    check("rst_pop_ins",    pop_ins,    0);
    check("rst_pop_exc",    pop_exc,    0);
    check("rst_pop_pc",     pop_pc,     0);
    check("rst_push_ready", push_ready, 1);
    check("rst_count",      count,      0);

    // Three pushes, then three pops in order
    for (int i = 0; i < 3; i++) begin
      drive_push(32'hBFC0_0000 + 32'(4 * i), 32'h100 + 32'(i), 4'h0);
      step();
      if (i == 0) begin
        check("lat1_pop_valid", pop_valid, 1);
        check("lat1_pop_pc",    pop_pc,    32'hBFC0_0000);
      end
    end
    push_valid = 1'b0;
    check("three_count", count, 3);
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("order_pc",  pop_pc,  32'hBFC0_0000 + 32'(4 * i));
      check("order_ins", pop_ins, 32'h100 + 32'(i));
      step();
    end
    pop_ready = 1'b0;
    check("drain_count",     count,     0);
    check("drain_pop_valid", pop_valid, 0);
    check("drain_pop_pc",    pop_pc,    0);

    // Fill to full; 5th push rejected; pop at full frees one slot
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h1000 + 32'(4 * i), 32'h200 + 32'(i), 4'h0);
      step();
    end
    check("full_count",      count,      4);
    check("full_push_ready", push_ready, 0);
    drive_push(32'h2000, 32'h2FF, 4'h0);
    step();
    check("full_reject_count", count,      4);
    check("full_reject_ready", push_ready, 0);
    pop_ready = 1'b1;
    step();
    push_valid = 1'b0;
    check("full_pop_count", count,      3);
    check("full_pop_ready", push_ready, 1);
    for (int i = 1; i < 4; i++) begin
      check("full_order_pc", pop_pc, 32'h1000 + 32'(4 * i));
      step();
    end
    pop_ready = 1'b0;
    check("full_drain_count", count, 0);

    // Streaming push+pop at count 1 across several wraps
    drive_push(32'h3000, 32'h300, 4'h0);
    step();
    check("stream_start_count", count, 1);
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(32'h3004 + 32'(4 * i), 32'h301 + 32'(i), 4'h0);
      check("stream_pc", pop_pc, 32'h3000 + 32'(4 * i));
      step();
      check("stream_count", count, 1);
    end
    push_valid = 1'b0;
    check("stream_last_pc", pop_pc, 32'h3028);
    step();
    pop_ready = 1'b0;
    check("stream_end_count", count, 0);

    // Exception entry passes through unchanged
    drive_push(32'h4000, 32'hDEAD_BEEF, 4'h4);
    step();
    push_valid = 1'b0;
    check("exc_code", pop_exc, 4'h4);
    check("exc_ins",  pop_ins, 32'hDEAD_BEEF);
    check("exc_pc",   pop_pc,  32'h4000);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    check("exc_empty_exc", pop_exc, 0);
    check("exc_empty_ins", pop_ins, 0);

    // Flush at count 3 with push and pop requested
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h5000 + 32'(4 * i), 32'h500 + 32'(i), 4'h0);
      step();
    end
    check("pre_flush_count", count, 3);
    flush = 1'b1; pop_ready = 1'b1;
    drive_push(32'h5FF0, 32'h5FF, 4'h0);
    step();
    flush = 1'b0; pop_ready = 1'b0; push_valid = 1'b0;
    check("flush_count",      count,      0);
    check("flush_pop_valid",  pop_valid,  0);
    check("flush_push_ready", push_ready, 1);
    drive_push(32'h5100, 32'h510, 4'h0);
    step();
    push_valid = 1'b0;
    check("post_flush_pc",    pop_pc, 32'h5100);
    check("post_flush_count", count,  1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive_push(32'h5200 + 32'(4 * i), 32'h520 + 32'(i), 4'h0);
      step();
    end
    push_valid = 1'b0;
    check("pre_rst_count", count, 3);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_count",      count,      0);
    check("async_rst_pop_valid",  pop_valid,  0);
    check("async_rst_pop_ins",    pop_ins,    0);
    check("async_rst_pop_pc",     pop_pc,     0);
    check("async_rst_push_ready", push_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    drive_push(32'h6000, 32'h600, 4'h0);
    step();
    push_valid = 1'b0;
    check("post_rst_pc",    pop_pc, 32'h6000);
    check("post_rst_count", count,  1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
